// File: rtl/jtag_wb_master.sv
// ---------------------------------------------------------------------------
// jtag_wb_master
// Bridges single debug-register commands from a JTAG host onto a pipelined
// Wishbone bus. Each accepted command issues exactly one strobe to the debug
// slave at word address ADDR, waits for ACK (bounded by TIMEOUT cycles) and
// returns a one-cycle response pulse.
//
// Ports
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o   command handshake (ready only when idle)
//   cmd_we_i                  1 = write debug register, 0 = read
//   cmd_data_i, cmd_addr_i    write payload (8-bit data, 3-bit register)
//   rsp_valid_o               one-cycle pulse, transaction finished
//   rsp_data_o, rsp_addr_o    read payload (wb_dat_i[10:3], wb_dat_i[2:0])
//   rsp_err_o                 1 = transaction aborted by timeout
//   wb_*                      pipelined Wishbone master interface
// ---------------------------------------------------------------------------
module jtag_wb_master #(
    parameter logic [31:0] ADDR    = 32'h0,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [7:0]  cmd_data_i,
    input  logic [2:0]  cmd_addr_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic [2:0]  rsp_addr_o,
    output logic        rsp_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // The counter equals k during the (k+1)-th bus cycle, so the abort
    // decision is taken in the cycle where it reads TIMEOUT-1.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 32'd1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        we_r;
    logic [7:0]  data_r;
    logic [2:0]  addr_r;
    logic [15:0] cnt_r;
    logic [7:0]  rsp_data_r;
    logic [2:0]  rsp_addr_r;
    logic        rsp_err_r;

    logic        accept_s;
    logic        busy_s;
    logic        ack_ok_s;
    logic        timeout_s;
    logic        finish_s;
    logic        unused_dat_s;

    assign accept_s  = (state_r == ST_IDLE) && cmd_valid_i;
    assign busy_s    = (state_r == ST_REQ) || (state_r == ST_WAIT);
    // An ACK only counts once the strobe has been taken (stall low) or while
    // waiting; ACKs in IDLE/DONE are ignored.
    assign ack_ok_s  = wb_ack_i && (((state_r == ST_REQ) && !wb_stall_i) ||
                                    (state_r == ST_WAIT));
    assign timeout_s = busy_s && (cnt_r == TO_LAST);
    assign finish_s  = busy_s && (ack_ok_s || timeout_s);
    assign unused_dat_s = ^{wb_dat_i[31:11]};

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; ACK has priority over a coincident timeout
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid_i) state_nxt_s = ST_REQ;
                else             state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (finish_s)         state_nxt_s = ST_DONE;
                else if (!wb_stall_i) state_nxt_s = ST_WAIT;
                else                  state_nxt_s = ST_REQ;
            end
            ST_WAIT: begin
                if (finish_s) state_nxt_s = ST_DONE;
                else          state_nxt_s = ST_WAIT;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        cmd_ready_o = 1'b0;
        wb_cyc_o    = 1'b0;
        wb_stb_o    = 1'b0;
        wb_we_o     = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_r)
            ST_IDLE: cmd_ready_o = 1'b1;
            ST_REQ: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = we_r;
            end
            ST_WAIT: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = we_r;
            end
            ST_DONE: rsp_valid_o = 1'b1;
            default: cmd_ready_o = 1'b0;
        endcase
    end

    // Command latch, captured on acceptance so bus data stays stable
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_r   <= 1'b0;
            data_r <= 8'h00;
            addr_r <= 3'h0;
        end else if (accept_s) begin
            we_r   <= cmd_we_i;
            data_r <= cmd_data_i;
            addr_r <= cmd_addr_i;
        end else begin
            we_r   <= we_r;
            data_r <= data_r;
            addr_r <= addr_r;
        end
    end

    // Saturating timeout counter, cleared on command acceptance
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r <= 16'h0000;
        end else if (accept_s) begin
            cnt_r <= 16'h0000;
        end else if (busy_s && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'h0001;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Response registers: loaded on entry to DONE, held until the next one
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_data_r <= 8'h00;
            rsp_addr_r <= 3'h0;
            rsp_err_r  <= 1'b0;
        end else if (finish_s && ack_ok_s) begin
            rsp_data_r <= we_r ? 8'h00 : wb_dat_i[10:3];
            rsp_addr_r <= we_r ? 3'h0  : wb_dat_i[2:0];
            rsp_err_r  <= 1'b0;
        end else if (finish_s) begin
            rsp_data_r <= 8'h00;
            rsp_addr_r <= 3'h0;
            rsp_err_r  <= 1'b1;
        end else begin
            rsp_data_r <= rsp_data_r;
            rsp_addr_r <= rsp_addr_r;
            rsp_err_r  <= rsp_err_r;
        end
    end

    assign rsp_data_o = rsp_data_r;
    assign rsp_addr_o = rsp_addr_r;
    assign rsp_err_o  = rsp_err_r;
    assign wb_adr_o   = ADDR;
    assign wb_sel_o   = 4'hF;
    assign wb_dat_o   = {21'h000000, data_r, addr_r};

endmodule
